// File: rtl/ula_defs.sv
// Shared opcode constants, FSM encoding and default width for the ULA sequencer.
// Pure definitions: no logic, no latency.
package ula_defs;

    localparam int DEF_WIDTH = 4;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_NOT  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/ula_shift_add_mul.sv
// Iterative shift-add multiplier: load clears state, each step retires one multiplier bit.
// WIDTH steps per product; product shows the accumulator value after the current step.
module ula_shift_add_mul #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               last
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    // Exposing the post-step value lets the sequencer capture the final
    // product on the same edge as the last iteration.
    assign product = acc + (mplier[0] ? mcand : '0);
    assign last    = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
        end else if (step) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ula_op_sequencer.sv
// ULA sequencer: 1-cycle ops or WIDTH-cycle multiply, one-cycle done pulse; start ignored while busy.
// Sticky overflow flag is built only when ULA_STICKY_OVF_EN is defined.
module ula_op_sequencer
    import ula_defs::*;
#(
    parameter int         WIDTH  = DEF_WIDTH,
    parameter logic [2:0] MUL_OP = OP_MUL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_ovf,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] prod_hi,
    output logic             ovf,
    output logic             zero,
    output logic             ovf_sticky
);

    state_t             state, state_nxt;
    logic [2:0]         op_sel;
    logic [WIDTH-1:0]   op_a, op_b;
    logic               load, step, complete, mul_last;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   res_nxt, hi_nxt;
    logic               ovf_nxt;

    ula_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .a       (a),
        .b       (b),
        .product (product),
        .last    (mul_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            op_sel <= '0;
            op_a   <= '0;
            op_b   <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                op_sel <= sel;
                op_a   <= a;
                op_b   <= b;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        complete  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (op_sel == MUL_OP) begin
                    step = 1'b1;
                    if (mul_last) begin
                        complete  = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end else begin
                    complete  = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign sum = {1'b0, op_a} + {1'b0, op_b};

    always_comb begin
        res_nxt = op_a;
        hi_nxt  = '0;
        ovf_nxt = 1'b0;
        if (op_sel == MUL_OP) begin
            res_nxt = product[WIDTH-1:0];
            hi_nxt  = product[2*WIDTH-1:WIDTH];
            ovf_nxt = |product[2*WIDTH-1:WIDTH];
        end else begin
            case (op_sel)
                OP_ADD: begin
                    res_nxt = sum[WIDTH-1:0];
                    ovf_nxt = sum[WIDTH];
                end
                OP_SUB: begin
                    res_nxt = op_a - op_b;
                    ovf_nxt = (op_a < op_b);
                end
                OP_AND:  res_nxt = op_a & op_b;
                OP_OR:   res_nxt = op_a | op_b;
                OP_XOR:  res_nxt = op_a ^ op_b;
                OP_NOT:  res_nxt = ~op_a;
                default: res_nxt = op_a;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result  <= '0;
            prod_hi <= '0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else if (complete) begin
            result  <= res_nxt;
            prod_hi <= hi_nxt;
            ovf     <= ovf_nxt;
            zero    <= (res_nxt == '0);
        end
    end

`ifdef ULA_STICKY_OVF_EN
    // A completion that overflows outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (complete && ovf_nxt) begin
            ovf_sticky <= 1'b1;
        end else if (clr_ovf && !complete) begin
            ovf_sticky <= 1'b0;
        end
    end
`else
    logic unused_clr_ovf;
    assign unused_clr_ovf = clr_ovf;
    assign ovf_sticky     = 1'b0;
`endif

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_ula_op_sequencer.sv
// Scoreboard bench for ula_op_sequencer: expected results queued at start, compared on done.
module tb_ula_op_sequencer;
    import ula_defs::*;

    logic       clk = 1'b0;
    logic       rst, start, clr_ovf;
    logic [2:0] sel;
    logic [3:0] a, b;
    logic       busy, done, ovf, zero, ovf_sticky;
    logic [3:0] result, prod_hi;

    typedef struct {
        logic [3:0] res;
        logic [3:0] hi;
        logic       ovf;
        logic       zero;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic exp_sticky = 1'b0;

    ula_op_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sel        (sel),
        .a          (a),
        .b          (b),
        .clr_ovf    (clr_ovf),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .prod_hi    (prod_hi),
        .ovf        (ovf),
        .zero       (zero),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] s, input logic [3:0] x, input logic [3:0] y);
        exp_t e;
        int   p;
        e.hi  = 4'd0;
        e.ovf = 1'b0;
        e.lat = (s == OP_MUL) ? 4 : 1;
        case (s)
            OP_ADD: begin p = int'(x) + int'(y); e.res = p[3:0]; e.ovf = (p > 15); end
            OP_SUB: begin e.res = x - y; e.ovf = (x < y); end
            OP_MUL: begin p = int'(x) * int'(y); e.res = p[3:0]; e.hi = p[7:4]; e.ovf = (p > 15); end
            OP_AND:  e.res = x & y;
            OP_OR:   e.res = x | y;
            OP_XOR:  e.res = x ^ y;
            OP_NOT:  e.res = ~x;
            default: e.res = x;
        endcase
        e.zero = (e.res == 4'd0);
        return e;
    endfunction

    // inject >= 2 pulses a spurious start with scrambled operands mid-operation.
    task automatic do_op(input logic [2:0] s, input logic [3:0] x, input logic [3:0] y, input int inject);
        exp_t e;
        int   busy_n;
        bit   seen;
        @(negedge clk);
        sel = s; a = x; b = y; start = 1'b1;
        sb.push_back(model(s, x, y));
        seen   = 1'b0;
        busy_n = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                seen = 1'b1;
                e = sb.pop_front();
`ifdef ULA_STICKY_OVF_EN
                if (e.ovf) exp_sticky = 1'b1;
`endif
                chk("latency", i - 1, e.lat);
                chk("busy_cycles", busy_n, e.lat + 1);
                chk("result", result, e.res);
                chk("prod_hi", prod_hi, e.hi);
                chk("ovf", ovf, e.ovf);
                chk("zero", zero, e.zero);
                chk("ovf_sticky", ovf_sticky, exp_sticky);
            end
            if (inject >= 2 && i == inject) begin
                start = 1'b1; a = ~x; b = ~y; sel = OP_ADD;
            end else if (inject >= 2 && i == inject + 1) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!seen) begin
            chk("done_timeout", 0, 1);
            e = sb.pop_front();
        end else begin
            @(negedge clk);
            chk("done_pulse", done, 0);
            chk("idle_busy", busy, 0);
            chk("hold_result", result, e.res);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; clr_ovf = 1'b0; sel = 3'd0; a = 4'd0; b = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_prod_hi", prod_hi, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_zero", zero, 0);
        chk("rst_sticky", ovf_sticky, 0);

        do_op(OP_MUL, 4'd3, 4'd5, 0);
        do_op(OP_MUL, 4'd4, 4'd4, 0);
        do_op(OP_MUL, 4'd15, 4'd15, 0);
        do_op(OP_ADD, 4'd9, 4'd8, 0);
        do_op(OP_SUB, 4'd3, 4'd5, 0);
        do_op(OP_SUB, 4'd9, 4'd4, 0);
        do_op(OP_AND, 4'd12, 4'd10, 0);
        do_op(OP_OR, 4'd12, 4'd3, 0);
        do_op(OP_XOR, 4'd5, 4'd5, 0);
        do_op(OP_NOT, 4'd15, 4'd2, 0);
        do_op(OP_PASS, 4'd7, 4'd1, 0);
        do_op(OP_MUL, 4'd0, 4'd9, 0);
        do_op(OP_ADD, 4'd1, 4'd1, 0);

        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        exp_sticky = 1'b0;
        chk("sticky_cleared", ovf_sticky, 0);

        do_op(OP_MUL, 4'd4, 4'd4, 2);
        do_op(OP_MUL, 4'd7, 4'd6, 3);

        // Start held high re-triggers every third cycle: IDLE, EXEC, DONE.
        @(negedge clk);
        sel = OP_ADD; a = 4'd2; b = 4'd3; start = 1'b1;
        n = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (done) n++;
        end
        start = 1'b0;
        chk("held_start_dones", n, 3);
        chk("held_start_result", result, 5);
        repeat (2) @(negedge clk);

        // Reset during the second multiply iteration aborts without a done pulse.
        do_op(OP_MUL, 4'd4, 4'd4, 0);
        @(negedge clk);
        sel = OP_MUL; a = 4'd6; b = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_prod_hi", prod_hi, 0);
        chk("abort_ovf", ovf, 0);
        chk("abort_zero", zero, 0);
        chk("abort_sticky", ovf_sticky, 0);
        exp_sticky = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) n++;
        end
        chk("abort_no_done", n, 0);

        do_op(OP_MUL, 4'd2, 4'd3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ula_op_sequencer.md
Name: ula_op_sequencer

Overview:
Registered sequencer for the 4-bit ULA datapath. Latches operands and the 3-bit opcode on a start pulse, then either executes a single-cycle op or runs a 4-iteration shift-add multiply. Produces the 4-bit result, the product high nibble, overflow (product high nibble nonzero for multiply) and zero flags, and a done/busy handshake. Sits between the switch/operand front end and the display/flag LEDs.

Parameters:
WIDTH, 4, operand/result width; multiply iteration count equals WIDTH
MUL_OP, 3'b010, opcode that selects the iterative multiply

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
sel  input  3  opcode, latched with start
a  input  WIDTH  operand A, latched with start
b  input  WIDTH  operand B, latched with start
clr_ovf  input  1  clears sticky overflow (see Optional Feature)
busy  output  1  high in EXEC and DONE
done  output  1  one-cycle pulse when result valid
result  output  WIDTH  low nibble of the operation
prod_hi  output  WIDTH  high nibble of the product; 0 for non-multiply ops
ovf  output  1  overflow flag of the last completed op
zero  output  1  result == 0
ovf_sticky  output  1  sticky overflow

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, prod_hi=0, ovf=0, zero=0, ovf_sticky=0, internal registers cleared. Reset mid-operation aborts immediately; the partial result is discarded.
- Opcodes: 000 add, 001 sub (A-B), 010 mul, 011 and, 100 or, 101 xor, 110 not A, 111 pass A.
- FSM states: IDLE, EXEC, DONE. Two-bit encoding.
- IDLE: when start=1 at edge k, latch a, b and sel, clear the accumulator and iteration count, go to EXEC.
- EXEC, non-mul: compute at edge k+1, register the outputs, go to DONE.
- EXEC, mul: accumulator is 2*WIDTH bits, multiplicand is 2*WIDTH bits, multiplier is WIDTH bits.
  - Per cycle: if multiplier[0]=1, add the multiplicand to the accumulator.
  - Shift the multiplicand left and the multiplier right; increment the count.
  - After WIDTH iterations (edge k+WIDTH), register the outputs and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. Output latency from the start edge: 1 cycle for non-mul ops, WIDTH cycles for mul.
- Flags:
  - mul: ovf = |acc[7:4]; prod_hi = acc[7:4].
  - add: ovf = carry out.
  - sub: ovf = borrow (A<B).
  - Logic ops: ovf=0.
  - zero = (result==0), independent of ovf.
- result, prod_hi, ovf and zero hold until the next completion or reset. They do not change while busy.
- start while busy=1 is ignored and not queued. start held high continuously re-triggers from IDLE every cycle after DONE.
- Operand or sel changes during EXEC have no effect.

Optional Feature:
- Macro: ULA_STICKY_OVF_EN.
- When defined:
  - ovf_sticky sets on any completion with ovf=1.
  - ovf_sticky clears on clr_ovf=1 in a cycle with no completion.
  - Simultaneous completion-with-ovf and clr_ovf: set wins.
- When undefined: ovf_sticky is tied 0 and clr_ovf is ignored. Both ports remain.

Decomposition:
- Shared include/package (ula_defs): opcode constants (OP_ADD through OP_PASS), FSM state encodings, default WIDTH.
- One sub-module, ula_shift_add_mul: holds the accumulator, multiplicand, multiplier and iteration count. Inputs: load and step. Outputs: product and last.
- The sequencer owns the FSM, the single-cycle ops and the flag registers.

Test Plan:
- Reset for 2 cycles, then idle: all outputs 0, busy=0.
- Mul 3x5: start with a=3, b=5, sel=010 → done after 4 cycles, result=15, prod_hi=0, ovf=0, zero=0; busy high for 5 cycles.
- Mul 4x4: → result=0, prod_hi=1, ovf=1, zero=1. Mul 15x15 → result=1, prod_hi=14, ovf=1.
- Add 9+8 → done 1 cycle after start, result=1, ovf=1. Sub 3-5 → result=14, ovf=1.
- Re-assert start with new operands during a mul's EXEC: ignored; the first result is intact. Assert rst at iteration 2: next cycle all outputs 0, state IDLE, no done pulse.
- With ULA_STICKY_OVF_EN: 4x4 → ovf_sticky=1. Then 1+1: ovf=0, ovf_sticky stays 1. clr_ovf → 0. Without the macro, ovf_sticky stays 0 throughout.
